sign_arith_pipe: RTL
====================

SIGN_ARITH_PIPE -- requirements
Module: sign_arith_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (legal 2..32).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-007 SHALL have port a  input  WIDTH  operand A, two's complement or unsigned per mode.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port mode  input  2  operation select, captured with the beat.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts when out_valid && out_ready.
REQ-012 SHALL have ports ans1, ans2, ans3  output  WIDTH each  result words.
REQ-013 SHALL have port ovf  output  1  signed overflow flag of ans1.

Function
REQ-014 SHALL be a 2-stage pipeline: stage 1 registers a, b, mode; stage 2 registers results; latency 2 cycles from acceptance to out_valid with no stall.
REQ-015 SHALL drive in_ready = !(out_valid && !out_ready); when low, both stages hold; no beat dropped or duplicated.
REQ-016 SHALL accept one beat per cycle at full throughput when out_ready is held high.
REQ-017 mode 0: ans1 = a+b mod 2^WIDTH; ans2 = signed a >>> b[SHW-1:0]; ans3 = unsigned a >> b[SHW-1:0]; ovf = signed add overflow.
REQ-018 mode 1: ans1 = a-b mod 2^WIDTH; ans2 = zero-extended (signed a < signed b); ans3 = zero-extended (unsigned a < unsigned b); ovf = signed sub overflow.
REQ-019 mode 2: ans1 = signed max(a,b); ans2 = signed min(a,b); ans3 = unsigned max(a,b); ovf = 0.
REQ-020 mode 3: accumulator acc <= acc + signed a at stage-2 capture; ans1 = new acc; ans2 = previous acc; ans3 = count of mode-3 beats mod 2^WIDTH including this one; ovf = signed overflow of the add; b ignored.
REQ-021 Back-to-back mode-3 beats SHALL each see the acc value left by the preceding beat (no hazard bubble).
REQ-022 acc and count SHALL update only when a mode-3 beat enters stage 2, never during a stall.
REQ-023 Result outputs SHALL stay stable while out_valid && !out_ready.

Reset
REQ-024 While reset==0 at a clock edge: stage valids, out_valid, ans1, ans2, ans3, ovf, acc, count SHALL become 0.
REQ-025 Reset mid-operation SHALL discard all in-flight beats; in_ready SHALL read 1 during and after reset.
REQ-026 First beat accepted after reset release SHALL appear on out_valid exactly 2 cycles later.

Configuration
REQ-027 With SIGN_ARITH_SAT_EN defined, modes 0, 1, 3 SHALL saturate ans1 (and acc) to signed max/min on overflow, ovf still asserted.
REQ-028 Without SIGN_ARITH_SAT_EN, those results SHALL wrap mod 2^WIDTH.

Verification (WIDTH=4)
REQ-029 mode0 a=3,b=1 -> after 2 cycles ans1=4, ans2=1, ans3=1, ovf=0.
REQ-030 mode0 a=-2(4'hE),b=1 -> ans1=4'hF, ans2=4'hF, ans3=4'h7; mode1 same operands -> ans1=4'hD, ans2=1, ans3=0.
REQ-031 mode2 a=4'hE,b=1 -> ans1=1, ans2=4'hE, ans3=4'hE.
REQ-032 mode0 a=7,b=1 -> ans1=4'h8, ovf=1 without macro; ans1=4'h7, ovf=1 with SIGN_ARITH_SAT_EN.
REQ-033 mode3 beats a=3,3,3 back-to-back -> ans1=3,6,4'h9 (ovf=1 on third; 4'h7 with macro), ans3=1,2,3.
REQ-034 out_ready low 3 cycles with 4 beats offered -> in_ready low, outputs stable, all 4 results delivered in order, then reset pulse mid-stream -> out_valid=0, acc=0 next cycle.

Source files
------------

// File: rtl/sign_arith_pipe.sv
// sign_arith_pipe: two-stage signed/unsigned arithmetic pipeline with a valid/ready handshake and a running accumulator.
// Define SIGN_ARITH_SAT_EN to saturate ans1 and acc on signed overflow (modes 0, 1 and 3); by default they wrap.
module sign_arith_pipe #(
    parameter int WIDTH = 4,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans1,
    output logic [WIDTH-1:0] ans2,
    output logic [WIDTH-1:0] ans3,
    output logic             ovf
);
`ifdef SIGN_ARITH_SAT_EN
    localparam bit sat = 1'b1;
`else
    localparam bit sat = 1'b0;
`endif
    localparam logic [WIDTH-1:0] smax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] smin = {1'b1, {(WIDTH-1){1'b0}}};
    logic             v1;
    logic [WIDTH-1:0] a1, b1, acc, cnt;
    logic [1:0]       m1;
    logic [WIDTH-1:0] sum, dif, accs, sra, r1, r2, r3;
    logic             o_add, o_sub, o_acc, slt, ult, ro;
    // neg is the operand sign, which is also the direction of any overflow
    function automatic logic [WIDTH-1:0] fix(input logic [WIDTH-1:0] r, input logic o, input logic neg);
        return (sat && o) ? (neg ? smin : smax) : r;
    endfunction
    assign in_ready = !(out_valid && !out_ready);
    always_comb begin
        sum   = a1 + b1;
        dif   = a1 - b1;
        accs  = acc + a1;
        sra   = $signed(a1) >>> b1[SHW-1:0];
        o_add = (a1[WIDTH-1] == b1[WIDTH-1]) && (sum[WIDTH-1] != a1[WIDTH-1]);
        o_sub = (a1[WIDTH-1] != b1[WIDTH-1]) && (dif[WIDTH-1] != a1[WIDTH-1]);
        o_acc = (acc[WIDTH-1] == a1[WIDTH-1]) && (accs[WIDTH-1] != acc[WIDTH-1]);
        slt   = $signed(a1) < $signed(b1);
        ult   = a1 < b1;
        r1 = m1 == 2'd0 ? fix(sum, o_add, a1[WIDTH-1]) :
             m1 == 2'd1 ? fix(dif, o_sub, a1[WIDTH-1]) :
             m1 == 2'd2 ? (slt ? b1 : a1) : fix(accs, o_acc, acc[WIDTH-1]);
        r2 = m1 == 2'd0 ? sra :
             m1 == 2'd1 ? {{(WIDTH-1){1'b0}}, slt} :
             m1 == 2'd2 ? (slt ? a1 : b1) : acc;
        r3 = m1 == 2'd0 ? a1 >> b1[SHW-1:0] :
             m1 == 2'd1 ? {{(WIDTH-1){1'b0}}, ult} :
             m1 == 2'd2 ? (ult ? b1 : a1) : cnt + 1'b1;
        ro = m1 == 2'd0 ? o_add : m1 == 2'd1 ? o_sub : m1 == 2'd3 ? o_acc : 1'b0;
    end
    // Both stages advance together, so a stalled output freezes the whole pipe
    always_ff @(posedge clk) begin
        if (!reset) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            ans1      <= '0;
            ans2      <= '0;
            ans3      <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else if (in_ready) begin
            v1        <= in_valid;
            out_valid <= v1;
            if (in_valid) begin
                a1 <= a;
                b1 <= b;
                m1 <= mode;
            end
            if (v1) begin
                ans1 <= r1;
                ans2 <= r2;
                ans3 <= r3;
                ovf  <= ro;
                if (m1 == 2'd3) begin
                    acc <= r1;
                    cnt <= r3;
                end
            end
        end
    end
endmodule
